// File: rtl/core_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states
// and the byte-enable width.
package core_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {IDLE, CHECK, BUS, RESP} lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: legality check, store byte enables and lane
// replication, and load byte/half extraction with sign or zero extension.
module lsu_align
  import core_pkg::*;
(
  input  logic            we,
  input  logic [2:0]      func3,
  input  logic [1:0]      addr_lo,
  input  logic [31:0]     store_data,
  input  logic [31:0]     load_word,
  output logic            fault,
  output logic [BE_W-1:0] be,
  output logic [31:0]     lane_data,
  output logic [31:0]     load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        illegal;
  logic        misaligned;

  always_comb begin
    byte_sel   = load_word[{addr_lo, 3'b000} +: 8];
    half_sel   = load_word[{addr_lo[1], 4'b0000} +: 16];
    illegal    = we ? !(func3 inside {F3_B, F3_H, F3_W})
                    : !(func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned = ((func3 == F3_H || func3 == F3_HU) && addr_lo[0]) ||
                 (func3 == F3_W && addr_lo != 2'b00);
    fault      = illegal || misaligned;
    be         = '0;
    lane_data  = '0;
    load_data  = '0;
    case (func3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << addr_lo;
        lane_data = {4{store_data[7:0]}};
        load_data = (func3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      end
      F3_H, F3_HU: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{store_data[15:0]}};
        load_data = (func3 == F3_H) ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      end
      F3_W: begin
        be        = 4'b1111;
        lane_data = store_data;
        load_data = load_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: latches a core request, rejects illegal or
// misaligned accesses, and runs one word access on a ready-handshake memory bus.
module load_store_unit
  import core_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BE_W-1:0]   mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_t        state, state_nxt;
  logic              we_q;
  logic [2:0]        func3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              timeout_hit;
  logic              fault_c;
  logic [BE_W-1:0]   be_c;
  logic [31:0]       lane_c;
  logic [31:0]       load_c;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  lsu_align u_align (
    .we        (we_q),
    .func3     (func3_q),
    .addr_lo   (addr_q[1:0]),
    .store_data(wdata_q),
    .load_word (mem_rdata),
    .fault     (fault_c),
    .be        (be_c),
    .lane_data (lane_c),
    .load_data (load_c)
  );

  // Gated by reset so the core is released the instant reset asserts.
  assign stall       = reset && req_valid && (state != RESP);
  assign done        = (state == RESP);
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = CHECK;
      CHECK:   state_nxt = fault_c ? RESP : BUS;
      BUS:     if (mem_ready || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q      <= 1'b0;
      func3_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wait_cnt  <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          func3_q <= req_func3;
          addr_q  <= req_addr[ADDR_W+1:0];
          wdata_q <= req_wdata;
        end
        CHECK: begin
          wait_cnt <= '0;
          if (fault_c) begin
            err   <= 1'b1;
            rdata <= '0;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= we_q;
            mem_addr  <= addr_q[ADDR_W+1:2];
            mem_be    <= be_c;
            mem_wdata <= we_q ? lane_c : '0;
          end
        end
        BUS: begin
          // A ready arriving on the last allowed cycle still wins over the timeout.
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err     <= 1'b0;
            rdata   <= we_q ? '0 : load_c;
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err     <= 1'b1;
            rdata   <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
